booth_mult_32: RTL and testbench



---
 rtl/booth_mult_32.sv | 143 ++++++++++++++
 tb/tb_booth_mult_32.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_32.sv
// Sequential signed 32x32 radix-2 Booth multiplier; 32-cycle latency (1..32 with BOOTH_EARLY_TERM_EN).
// Backpressure: start is ignored while busy; hi/lo hold the previous product until the done pulse.
module booth_mult_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic        state_q, state_d;
    logic        armed_q;
    logic [31:0] m_q, m_d;
    logic [31:0] q_q, q_d;
    logic [32:0] a_q, a_d;
    logic        qm1_q, qm1_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic [32:0] addend;
    logic        cin;
    logic [32:0] sum;
    logic [32:0] a_nxt;
    logic [31:0] q_nxt;
    logic        early_term;
    logic [63:0] early_prod;

    // A[32] stays a copy of A[31] between iterations, so {A[31:0], Q} carries the full sign.
`ifdef BOOTH_EARLY_TERM_EN
    logic [31:0] rem_mask;
    logic [5:0]  rem_k;
    assign rem_mask   = 32'hFFFF_FFFF >> cnt_q;
    assign rem_k      = 6'd32 - cnt_q;
    assign early_term = ((q_q ^ {32{qm1_q}}) & rem_mask) == 32'd0;
    assign early_prod = $signed({a_q[31:0], q_q}) >>> rem_k;
`else
    assign early_term = 1'b0;
    assign early_prod = 64'd0;
`endif

    always_comb begin
        addend = 33'd0;
        cin    = 1'b0;
        case ({q_q[0], qm1_q})
            2'b10: begin
                addend = ~{m_q[31], m_q};
                cin    = 1'b1;
            end
            2'b01:   addend = {m_q[31], m_q};
            default: addend = 33'd0;
        endcase
        sum   = a_q + addend + {32'd0, cin};
        a_nxt = {sum[32], sum[32:1]};
        q_nxt = {sum[0], q_q[31:1]};
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        a_d     = a_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && armed_q) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = 33'd0;
                    qm1_d   = 1'b0;
                    cnt_d   = 6'd0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (early_term) begin
                    hi_d    = early_prod[63:32];
                    lo_d    = early_prod[31:0];
                    done_d  = 1'b1;
                    cnt_d   = 6'd0;
                    state_d = ST_IDLE;
                end else begin
                    a_d   = a_nxt;
                    q_d   = q_nxt;
                    qm1_d = q_q[0];
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        hi_d    = a_nxt[31:0];
                        lo_d    = q_nxt;
                        done_d  = 1'b1;
                        cnt_d   = 6'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // armed_q blocks start on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
            m_q     <= 32'd0;
            q_q     <= 32'd0;
            a_q     <= 33'd0;
            qm1_q   <= 1'b0;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            m_q     <= m_d;
            q_q     <= q_d;
            a_q     <= a_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_booth_mult_32.sv
// Self-checking bench for booth_mult_32 against a plain-arithmetic product and latency model.
module tb_booth_mult_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] multiplicand = 32'd0;
    logic [31:0] multiplier = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    booth_mult_32 dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] q);
        longint a, b;
        a = longint'($signed(m));
        b = longint'($signed(q));
        return 64'(a * b);
    endfunction

    // Cycle c finishes early when Q bits c-2 and above are all the same (q-1 = 0 for c = 1).
    function automatic int ref_lat(input logic [31:0] q);
`ifdef BOOTH_EARLY_TERM_EN
        logic signed [31:0] s;
        if (q == 32'd0) return 1;
        for (int c = 2; c <= 32; c++) begin
            s = $signed(q) >>> (c - 2);
            if (s == 32'sd0 || s == -32'sd1) return c;
        end
        return 32;
`else
        return 32;
`endif
    endfunction

    task automatic run_op(input logic [31:0] m, input logic [31:0] q, input int poke_at,
                          input logic [31:0] pm, input logic [31:0] pq,
                          output int lat, output logic [63:0] prod,
                          output bit held, output bit busy_ok);
        logic [31:0] hi0, lo0;
        int cyc;
        hi0 = hi; lo0 = lo; held = 1'b1; busy_ok = 1'b1; lat = -1; prod = 64'hDEAD_DEAD_DEAD_DEAD;
        multiplicand = m; multiplier = q; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        cyc = 0;
        while (lat < 0 && cyc < 40) begin
            if (cyc + 1 == poke_at) begin
                start = 1'b1; multiplicand = pm; multiplier = pq;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                lat = cyc;
                prod = {hi, lo};
                if (busy !== 1'b0) busy_ok = 1'b0;
            end else begin
                if (hi !== hi0 || lo !== lo0) held = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (hi !== 32'd0) begin fails++; $display("FAIL reset_hi got %h want 0", hi); end
        tests++; if (lo !== 32'd0) begin fails++; $display("FAIL reset_lo got %h want 0", lo); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] vm [4] = '{32'd6, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vq [4] = '{32'd7, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [63:0] vp [4] = '{64'h0000_0000_0000_002A, 64'hFFFF_FFFF_FFFF_FFF1,
                                64'h4000_0000_0000_0000, 64'h0000_0000_8000_0000};
        int lat; logic [63:0] prod; bit held, bok;
        for (int i = 0; i < 4; i++) begin
            run_op(vm[i], vq[i], 0, 32'd0, 32'd0, lat, prod, held, bok);
            tests++; if (prod !== vp[i]) begin fails++; $display("FAIL dir%0d_prod got %h want %h", i, prod, vp[i]); end
            tests++; if (lat != ref_lat(vq[i])) begin fails++; $display("FAIL dir%0d_lat got %0d want %0d", i, lat, ref_lat(vq[i])); end
            tests++; if (!held) begin fails++; $display("FAIL dir%0d_hold got changed want held", i); end
            tests++; if (!bok) begin fails++; $display("FAIL dir%0d_busy got wrong busy want high-then-low", i); end
            @(posedge clk); #1;
            tests++; if (done !== 1'b0 || busy !== 1'b0) begin
                fails++; $display("FAIL dir%0d_after got done=%b busy=%b want 0/0", i, done, busy);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [63:0] prod; bit held, bok;
        logic [31:0] m, q;
        for (int i = 0; i < 24; i++) begin
            m = $urandom;
            q = $urandom;
            if (i % 3 == 0) q = q >> $urandom_range(1, 31);
            if (i % 4 == 1) q = ~(q >> $urandom_range(1, 31));
            run_op(m, q, 0, 32'd0, 32'd0, lat, prod, held, bok);
            tests++; if (prod !== ref_prod(m, q) || lat != ref_lat(q) || !held || !bok) begin
                fails++;
                $display("FAIL rand%0d m=%h q=%h got prod=%h lat=%0d held=%0b busy_ok=%0b want prod=%h lat=%0d",
                         i, m, q, prod, lat, held, bok, ref_prod(m, q), ref_lat(q));
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat; logic [63:0] prod; bit held, bok;
        run_op(32'h0000_1234, 32'h4000_0000, 10, 32'h7777_7777, 32'h0000_0003, lat, prod, held, bok);
        tests++; if (prod !== ref_prod(32'h0000_1234, 32'h4000_0000)) begin
            fails++; $display("FAIL ignore_prod got %h want %h", prod, ref_prod(32'h0000_1234, 32'h4000_0000));
        end
        tests++; if (lat != 32) begin fails++; $display("FAIL ignore_lat got %0d want 32", lat); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_no_restart got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] m1 = 32'hFFFF_0001, q1 = 32'h1234_5678;
        logic [31:0] m2 = 32'h0000_0BAD, q2 = 32'hFFFF_FF00;
        int d1 = -1, d2 = -1, cyc = 0;
        logic [63:0] p1 = '0, p2 = '0;
        multiplicand = m1; multiplier = q1; start = 1'b1;
        @(posedge clk); #1;
        multiplicand = m2; multiplier = q2;
        while (d2 < 0 && cyc < 90) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                if (d1 < 0) begin d1 = cyc; p1 = {hi, lo}; end
                else begin d2 = cyc; p2 = {hi, lo}; start = 1'b0; end
            end
        end
        start = 1'b0;
        tests++; if (d1 != ref_lat(q1)) begin fails++; $display("FAIL b2b_lat1 got %0d want %0d", d1, ref_lat(q1)); end
        tests++; if (p1 !== ref_prod(m1, q1)) begin fails++; $display("FAIL b2b_prod1 got %h want %h", p1, ref_prod(m1, q1)); end
        tests++; if (d2 != ref_lat(q1) + 1 + ref_lat(q2)) begin
            fails++; $display("FAIL b2b_lat2 got %0d want %0d", d2, ref_lat(q1) + 1 + ref_lat(q2));
        end
        tests++; if (p2 !== ref_prod(m2, q2)) begin fails++; $display("FAIL b2b_prod2 got %h want %h", p2, ref_prod(m2, q2)); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        int lat; logic [63:0] prod; bit held, bok; bit saw_done;
        run_op(32'd6, 32'd7, 0, 32'd0, 32'd0, lat, prod, held, bok);
        multiplicand = 32'h0000_0055; multiplier = 32'h4000_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL midrst_hilo got %h_%h want 0", hi, lo); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL midrst_ctrl got busy=%b done=%b want 0/0", busy, done);
        end
        saw_done = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (done !== 1'b0) saw_done = 1'b1; end
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1; end
        tests++; if (saw_done) begin fails++; $display("FAIL midrst_quiet got activity want none"); end
        run_op(32'hFFFF_FFF9, 32'd9, 0, 32'd0, 32'd0, lat, prod, held, bok);
        tests++; if (prod !== 64'hFFFF_FFFF_FFFF_FFC1 || lat != ref_lat(32'd9)) begin
            fails++; $display("FAIL midrst_after got prod=%h lat=%0d want ffffffffffffffc1 lat=%0d", prod, lat, ref_lat(32'd9));
        end
    endtask

    task automatic test_early_term();
        logic [31:0] em [4] = '{32'h89AB_CDEF, 32'h0000_0005, 32'h1234_5678, 32'd3};
        logic [31:0] eq [4] = '{32'd0, 32'hFFFF_FFFF, 32'd1, 32'h4000_0000};
        logic [63:0] ep [4] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0000_0000_1234_5678, 64'h0000_0000_C000_0000};
`ifdef BOOTH_EARLY_TERM_EN
        int el [4] = '{1, 2, 3, 32};
`else
        int el [4] = '{32, 32, 32, 32};
`endif
        int lat; logic [63:0] prod; bit held, bok;
        for (int i = 0; i < 4; i++) begin
            run_op(em[i], eq[i], 0, 32'd0, 32'd0, lat, prod, held, bok);
            tests++; if (prod !== ep[i] || lat != el[i]) begin
                fails++; $display("FAIL early%0d got prod=%h lat=%0d want prod=%h lat=%0d", i, prod, lat, ep[i], el[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        test_early_term();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no finish want finish before 400000");
        $fatal(1, "watchdog");
    end

endmodule
